// File: rtl/palette_pkg.sv
// Shared types and constants for the double-buffered palette lookup table.
// States are plain constants so older netlists and scripts can decode them.
package palette_pkg;

  localparam int LOOKUP_LAT = 2;

  typedef logic [1:0] state_t;
  localparam state_t ST_INIT = 2'd0;
  localparam state_t ST_IDLE = 2'd1;
  localparam state_t ST_PEND = 2'd2;
  localparam state_t ST_COPY = 2'd3;

  localparam int RGB_W = 4;

  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/palette_clut_db_if.sv
// Write, lookup and status signals of the palette block, grouped as one bundle.
interface palette_clut_db_if #(
  parameter int NUM_CH  = 2,
  parameter int IDX_W   = 8,
  parameter int COLOR_W = 4
) ();

  logic                      frame_start;
  logic                      wr_valid;
  logic                      wr_ready;
  logic [IDX_W-1:0]          wr_index;
  logic [3*COLOR_W-1:0]      wr_color;
  logic                      wr_commit;
  logic [NUM_CH-1:0]         rd_valid;
  logic [NUM_CH*IDX_W-1:0]   rd_index;
  logic [NUM_CH-1:0]         out_valid;
  logic [NUM_CH*COLOR_W-1:0] red;
  logic [NUM_CH*COLOR_W-1:0] green;
  logic [NUM_CH*COLOR_W-1:0] blue;
  logic [NUM_CH-1:0]         transparent;
  logic                      swap_pending;
  logic                      busy;

  modport master (
    output frame_start, wr_valid, wr_index, wr_color, wr_commit, rd_valid, rd_index,
    input  wr_ready, out_valid, red, green, blue, transparent, swap_pending, busy
  );

  modport slave (
    input  frame_start, wr_valid, wr_index, wr_color, wr_commit, rd_valid, rd_index,
    output wr_ready, out_valid, red, green, blue, transparent, swap_pending, busy
  );

endinterface

// File: rtl/palette_bank.sv
// One palette bank: a single write port and NRD asynchronous read ports.
module palette_bank #(
  parameter int IDX_W = 8,
  parameter int WIDTH = 12,
  parameter int NRD   = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [NRD*IDX_W-1:0]  raddr,
  output logic [NRD*WIDTH-1:0]  rdata
);

  localparam int DEPTH = 1 << IDX_W;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata = '0;
    for (int p = 0; p < NRD; p++)
      rdata[p*WIDTH +: WIDTH] = mem[raddr[p*IDX_W +: IDX_W]];
  end

endmodule

// File: rtl/palette_clut_db.sv
// Double-buffered colour lookup table: lookups read the front bank, writes fill
// the back bank, and a committed swap takes effect at the next frame start.
module palette_clut_db
  import palette_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int IDX_W      = 8,
  parameter int COLOR_W    = 4,
  parameter int TRANSP_IDX = 0
) (
  input logic               Clk,
  input logic               Reset,
  palette_clut_db_if.slave  bus
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int CW    = 3 * COLOR_W;
  localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] TRANSP_ID = IDX_W'(TRANSP_IDX);

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  logic              front_sel;
  logic              pending;
  logic              wr_fire;
  logic              last;

  logic                      we0, we1;
  logic [IDX_W-1:0]          waddr;
  logic [CW-1:0]             wdata;
  logic [(NUM_CH+1)*IDX_W-1:0] raddr;
  logic [(NUM_CH+1)*CW-1:0]  rdata0, rdata1;

  logic [NUM_CH-1:0]         v1;
  logic [NUM_CH*IDX_W-1:0]   idx1;
  logic                      sel1;
  logic                      init1;
  logic [NUM_CH*CW-1:0]      look;
  logic [NUM_CH-1:0]         v2, tr2;
  logic [NUM_CH*COLOR_W-1:0] red2, green2, blue2;

  assign wr_fire = bus.wr_valid && (state == ST_IDLE);
  assign last    = (cnt == LAST_ADDR);
  assign raddr   = {cnt, idx1};

  palette_bank #(.IDX_W(IDX_W), .WIDTH(CW), .NRD(NUM_CH + 1)) u_bank0 (
    .clk(Clk), .we(we0), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata0)
  );

  palette_bank #(.IDX_W(IDX_W), .WIDTH(CW), .NRD(NUM_CH + 1)) u_bank1 (
    .clk(Clk), .we(we1), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata1)
  );

  // INIT clears both banks; IDLE writes and COPY refresh only the back bank.
  always_comb begin
    we0   = 1'b0;
    we1   = 1'b0;
    waddr = bus.wr_index;
    wdata = bus.wr_color;
    case (state)
      ST_INIT: begin
        we0   = 1'b1;
        we1   = 1'b1;
        waddr = cnt;
        wdata = '0;
      end
      ST_IDLE: begin
        we0 = wr_fire && front_sel;
        we1 = wr_fire && !front_sel;
      end
      ST_COPY: begin
        we0   = front_sel;
        we1   = !front_sel;
        waddr = cnt;
        wdata = front_sel ? rdata1[NUM_CH*CW +: CW] : rdata0[NUM_CH*CW +: CW];
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_INIT;
      cnt       <= '0;
      front_sel <= 1'b0;
      pending   <= 1'b0;
    end else begin
      case (state)
        ST_INIT, ST_COPY: begin
          cnt <= cnt + IDX_W'(1);
          if (last) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        end
        ST_IDLE: begin
          if (bus.wr_commit) begin
            state   <= ST_PEND;
            pending <= 1'b1;
          end
        end
        ST_PEND: begin
          if (bus.frame_start) begin
            front_sel <= ~front_sel;
            pending   <= 1'b0;
            state     <= ST_COPY;
            cnt       <= '0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Bank choice is frozen at request time so a swap never splits a lookup.
  always_comb begin
    look = '0;
    for (int c = 0; c < NUM_CH; c++)
      look[c*CW +: CW] = sel1 ? rdata1[c*CW +: CW] : rdata0[c*CW +: CW];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      v1     <= '0;
      idx1   <= '0;
      sel1   <= 1'b0;
      init1  <= 1'b0;
      v2     <= '0;
      tr2    <= '0;
      red2   <= '0;
      green2 <= '0;
      blue2  <= '0;
    end else begin
      v1    <= bus.rd_valid;
      idx1  <= bus.rd_index;
      sel1  <= front_sel;
      init1 <= (state == ST_INIT);
      v2    <= v1;
      for (int c = 0; c < NUM_CH; c++) begin
        red2[c*COLOR_W +: COLOR_W]   <= (v1[c] && !init1) ? look[c*CW + 2*COLOR_W +: COLOR_W] : '0;
        green2[c*COLOR_W +: COLOR_W] <= (v1[c] && !init1) ? look[c*CW + COLOR_W +: COLOR_W] : '0;
        blue2[c*COLOR_W +: COLOR_W]  <= (v1[c] && !init1) ? look[c*CW +: COLOR_W] : '0;
        tr2[c] <= v1[c] && (idx1[c*IDX_W +: IDX_W] == TRANSP_ID);
      end
    end
  end

  assign bus.out_valid    = v2;
  assign bus.red          = red2;
  assign bus.green        = green2;
  assign bus.blue         = blue2;
  assign bus.transparent  = tr2;
  assign bus.wr_ready     = (state == ST_IDLE);
  assign bus.busy         = (state == ST_INIT) || (state == ST_COPY);
  assign bus.swap_pending = pending;

endmodule

// File: tb/tb_palette_clut_db.sv
// Scoreboard bench for palette_clut_db: lookups push the model's front-bank value
// and a negedge monitor pops and compares when the result is due.
module tb_palette_clut_db;
  import palette_pkg::*;

  localparam int NUM_CH = 2, IDX_W = 8, COLOR_W = 4, TRANSP_IDX = 0;
  localparam int DEPTH = 1 << IDX_W, CW = 3 * COLOR_W;

  typedef struct {
    int            due;
    int            ch;
    logic [CW-1:0] rgb;
    logic          tr;
  } exp_t;

  logic Clk, Reset;
  palette_clut_db_if #(.NUM_CH(NUM_CH), .IDX_W(IDX_W), .COLOR_W(COLOR_W)) bus ();

  palette_clut_db #(.NUM_CH(NUM_CH), .IDX_W(IDX_W), .COLOR_W(COLOR_W), .TRANSP_IDX(TRANSP_IDX)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );

  exp_t          sbq[$];
  logic [CW-1:0] front_m[DEPTH];
  logic [CW-1:0] back_m[DEPTH];
  int            cycle = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  bit            mon_en = 0;

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  // Results become visible two negedges after the request was driven.
  always @(negedge Clk) begin : monitor
    exp_t              e;
    rgb_t              act;
    logic [NUM_CH-1:0] seen;
    cycle = cycle + 1;
    if (mon_en) begin
      seen = '0;
      while (sbq.size() > 0 && sbq[0].due <= cycle) begin
        e = sbq.pop_front();
        act.r = bus.red[e.ch*COLOR_W +: COLOR_W];
        act.g = bus.green[e.ch*COLOR_W +: COLOR_W];
        act.b = bus.blue[e.ch*COLOR_W +: COLOR_W];
        seen[e.ch] = 1'b1;
        n_cmp++;
        if (e.due != cycle || bus.out_valid[e.ch] !== 1'b1 || act !== e.rgb || bus.transparent[e.ch] !== e.tr) begin
          n_err++;
          $display("[TB] FAIL lookup ch%0d cyc%0d: got v=%b rgb=%h t=%b, want v=1 rgb=%h t=%b (due %0d)",
                   e.ch, cycle, bus.out_valid[e.ch], act, bus.transparent[e.ch], e.rgb, e.tr, e.due);
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (!seen[c]) begin
          n_cmp++;
          if (bus.out_valid[c] !== 1'b0 || bus.red[c*COLOR_W +: COLOR_W] !== '0 ||
              bus.green[c*COLOR_W +: COLOR_W] !== '0 || bus.blue[c*COLOR_W +: COLOR_W] !== '0 ||
              bus.transparent[c] !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL idle_zero ch%0d cyc%0d: got v=%b r=%h g=%h b=%h t=%b, want all 0", c, cycle,
                     bus.out_valid[c], bus.red[c*COLOR_W +: COLOR_W], bus.green[c*COLOR_W +: COLOR_W],
                     bus.blue[c*COLOR_W +: COLOR_W], bus.transparent[c]);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(negedge Clk);
    #1;
    bus.rd_valid    = '0;
    bus.wr_valid    = 1'b0;
    bus.wr_commit   = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic lookup(input int ch, input int idx);
    bus.rd_valid[ch] = 1'b1;
    bus.rd_index[ch*IDX_W +: IDX_W] = IDX_W'(idx);
    sbq.push_back('{due: cycle + LOOKUP_LAT, ch: ch, rgb: front_m[idx], tr: (idx == TRANSP_IDX)});
  endtask

  task automatic write(input int idx, input logic [CW-1:0] col, input bit accepted);
    bus.wr_valid = 1'b1;
    bus.wr_index = IDX_W'(idx);
    bus.wr_color = col;
    if (accepted) back_m[idx] = col;
  endtask

  task automatic swap_model();
    for (int i = 0; i < DEPTH; i++) front_m[i] = back_m[i];
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 400) begin
      cyc();
      n++;
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL %s_timeout: busy=%b after %0d cycles, want 0", name, bus.busy, n);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    cyc();
    mon_en = 1;
    cyc();
    n_cmp++;
    if (bus.wr_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_wr_ready: got %b want 0", bus.wr_ready); end
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_err++; $display("[TB] FAIL reset_busy: got %b want 1", bus.busy); end
    n_cmp++;
    if (bus.swap_pending !== 1'b0) begin n_err++; $display("[TB] FAIL reset_pending: got %b want 0", bus.swap_pending); end
    for (int i = 0; i < DEPTH; i++) begin front_m[i] = '0; back_m[i] = '0; end
    Reset = 1'b0;
    for (int i = 1; i <= DEPTH + 2; i++) begin
      lookup(0, 5);
      cyc();
      n_cmp++;
      if (bus.busy !== (i < DEPTH)) begin
        n_err++;
        $display("[TB] FAIL init_busy step%0d: got %b want %b", i, bus.busy, (i < DEPTH));
      end
      n_cmp++;
      if (bus.wr_ready !== (i >= DEPTH)) begin
        n_err++;
        $display("[TB] FAIL init_wr_ready step%0d: got %b want %b", i, bus.wr_ready, (i >= DEPTH));
      end
    end
    cyc(); cyc();
  endtask

  task automatic test_write_swap();
    n_cmp++;
    if (bus.wr_ready !== 1'b1) begin n_err++; $display("[TB] FAIL idle_wr_ready: got %b want 1", bus.wr_ready); end
    write(5, 12'hFBB, 1);
    cyc();
    lookup(0, 5);
    cyc();
    bus.wr_commit = 1'b1;
    cyc();
    n_cmp++;
    if (bus.swap_pending !== 1'b1) begin n_err++; $display("[TB] FAIL commit_pending: got %b want 1", bus.swap_pending); end
    bus.frame_start = 1'b1;
    swap_model();
    cyc();
    n_cmp++;
    if (bus.swap_pending !== 1'b0) begin n_err++; $display("[TB] FAIL swap_pending_clear: got %b want 0", bus.swap_pending); end
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_err++; $display("[TB] FAIL copy_busy: got %b want 1", bus.busy); end
    cyc();
    lookup(0, 5);
    lookup(1, 5);
    cyc(); cyc(); cyc();
    wait_idle("copy1");
  endtask

  task automatic test_commit_same_frame();
    write(9, 12'h123, 1);
    bus.wr_commit   = 1'b1;
    bus.frame_start = 1'b1;
    cyc();
    n_cmp++;
    if (bus.swap_pending !== 1'b1) begin n_err++; $display("[TB] FAIL same_frame_pending: got %b want 1", bus.swap_pending); end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("[TB] FAIL same_frame_busy: got %b want 0", bus.busy); end
    lookup(0, 9);
    cyc();
    write(10, 12'hABC, 0);
    cyc();
    repeat (3) cyc();
    n_cmp++;
    if (bus.swap_pending !== 1'b1) begin n_err++; $display("[TB] FAIL pend_hold: got %b want 1", bus.swap_pending); end
    lookup(1, 9);
    cyc();
    lookup(0, 9);
    lookup(1, 10);
    bus.frame_start = 1'b1;
    swap_model();
    cyc();
    lookup(0, 9);
    lookup(1, 10);
    cyc();
    n_cmp++;
    if (bus.swap_pending !== 1'b0) begin n_err++; $display("[TB] FAIL late_swap_pending: got %b want 0", bus.swap_pending); end
    bus.wr_commit = 1'b1;
    cyc();
    wait_idle("copy2");
    n_cmp++;
    if (bus.swap_pending !== 1'b0) begin n_err++; $display("[TB] FAIL commit_in_copy: pending=%b want 0", bus.swap_pending); end
  endtask

  task automatic test_copy();
    write(5, 12'h7B4, 1);
    cyc();
    bus.wr_commit = 1'b1;
    cyc();
    bus.frame_start = 1'b1;
    swap_model();
    cyc();
    wait_idle("copy3");
    lookup(0, 5); lookup(1, 9); cyc();
    lookup(0, 10); lookup(1, 0); cyc();
    lookup(0, 255); lookup(1, 5); cyc();
    write(200, 12'h5A5, 1);
    cyc();
    bus.wr_commit = 1'b1;
    cyc();
    bus.frame_start = 1'b1;
    swap_model();
    cyc();
    wait_idle("copy4");
    lookup(0, 5); lookup(1, 200); cyc();
    lookup(0, 9); lookup(1, 1); cyc();
    cyc(); cyc();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) begin
      write(i, CW'(i * 12'h111 + 12'h020), 1);
      cyc();
    end
    bus.wr_commit = 1'b1;
    cyc();
    bus.frame_start = 1'b1;
    swap_model();
    cyc();
    wait_idle("copy5");
    for (int i = 0; i < 24; i++) begin
      lookup(0, int'($urandom_range(0, 12)));
      lookup(1, int'($urandom_range(0, 12)));
      cyc();
    end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_reset_mid_copy();
    write(3, 12'hEEE, 1);
    cyc();
    bus.wr_commit = 1'b1;
    cyc();
    bus.frame_start = 1'b1;
    swap_model();
    cyc();
    repeat (100) cyc();
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_err++; $display("[TB] FAIL mid_copy_busy: got %b want 1", bus.busy); end
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0 || bus.swap_pending !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL mid_copy_reset: busy=%b rdy=%b pend=%b want 1 0 0", bus.busy, bus.wr_ready, bus.swap_pending);
    end
    for (int i = 0; i < DEPTH; i++) begin front_m[i] = '0; back_m[i] = '0; end
    wait_idle("reinit");
    lookup(1, 0); lookup(0, 5); cyc();
    lookup(0, 3); lookup(1, 9); cyc();
    write(3, 12'h111, 1);
    cyc();
    lookup(0, 3);
    bus.wr_commit = 1'b1;
    cyc();
    bus.frame_start = 1'b1;
    swap_model();
    cyc();
    lookup(0, 3); lookup(1, 0); cyc();
    wait_idle("copy6");
    cyc(); cyc();
  endtask

  initial begin
    Reset           = 1'b1;
    bus.frame_start = 1'b0;
    bus.wr_valid    = 1'b0;
    bus.wr_index    = '0;
    bus.wr_color    = '0;
    bus.wr_commit   = 1'b0;
    bus.rd_valid    = '0;
    bus.rd_index    = '0;
    test_reset();
    test_write_swap();
    test_commit_same_frame();
    test_copy();
    test_back_to_back();
    test_reset_mid_copy();
    repeat (4) cyc();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("[TB] FAIL scoreboard_drain: %0d results outstanding, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/palette_clut_db.md
PALETTE_CLUT_DB -- requirements
Module: palette_clut_db

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter NUM_CH, default 2: number of independent lookup channels.
REQ-002 The block SHALL have parameter IDX_W, default 8: index width; each bank holds DEPTH = 2^IDX_W entries.
REQ-003 The block SHALL have parameter COLOR_W, default 4: width of each of the red, green and blue components.
REQ-004 The block SHALL have parameter TRANSP_IDX, default 0: the index that is flagged transparent.

Ports (name, direction, width, meaning):
REQ-005 Clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-006 Reset, input, 1: synchronous, active-high reset.
REQ-007 frame_start, input, 1: one-cycle pulse at the start of each video frame.
REQ-008 wr_valid, input, 1 / wr_ready, output, 1: write handshake into the back bank.
REQ-009 wr_index, input, IDX_W / wr_color, input, 3*COLOR_W: write address and colour, packed {R,G,B}.
REQ-010 wr_commit, input, 1: pulse requesting a bank swap at the next frame_start.
REQ-011 rd_valid, input, NUM_CH / rd_index, input, NUM_CH*IDX_W: per-channel lookup requests.
REQ-012 out_valid, output, NUM_CH / red, green, blue, output, NUM_CH*COLOR_W each / transparent, output, NUM_CH: per-channel lookup results.
REQ-013 swap_pending, output, 1: a commit has been accepted and the swap has not yet occurred.
REQ-014 busy, output, 1: high while the state machine is in INIT or COPY.

Function
REQ-015 The block SHALL hold two banks of DEPTH x 3*COLOR_W entries; front_sel selects the front bank used for lookups, and the other bank is the back bank used for writes.
REQ-016 Lookup latency SHALL be exactly 2 cycles per channel: out_valid[c] at cycle t+2 equals rd_valid[c] at cycle t, with no stalls.
REQ-017 Each lookup SHALL read the front bank as selected at request cycle t, even if a swap occurs at t or t+1.
REQ-018 transparent[c] SHALL be 1 when the delayed index equals TRANSP_IDX; colour SHALL still be output for that index.
REQ-019 When out_valid[c] is 0, red[c], green[c], blue[c] and transparent[c] SHALL be 0.
REQ-020 The state machine SHALL have states INIT, IDLE, PEND and COPY.
REQ-021 INIT: write 0 to address k of both banks in cycle k, for k = 0 to DEPTH-1; then go to IDLE. wr_ready=0; lookups return 0.
REQ-022 IDLE: wr_ready=1; a write occurs when wr_valid && wr_ready, into the back bank only, and is not visible to lookups.
REQ-023 IDLE with wr_commit=1: go to PEND and set swap_pending; a write handshaked in the same cycle SHALL be included in the swap.
REQ-024 PEND: wr_ready=0; frame_start is ignored in the cycle wr_commit is accepted; on the first later frame_start, toggle front_sel, clear swap_pending, and go to COPY.
REQ-025 COPY: copy new-front[k] to back[k] in cycle k, for k = 0 to DEPTH-1; wr_ready=0; then go to IDLE, leaving both banks identical.
REQ-026 wr_commit SHALL be ignored outside IDLE; writes offered while wr_ready=0 SHALL be dropped, and wr_valid SHALL be held by the source until ready.
REQ-027 The copy address counter SHALL be IDX_W bits wide; the state SHALL exit on the cycle the counter equals DEPTH-1, with no wrap into a second pass.

Reset
REQ-028 On Reset=1, the block SHALL set state=INIT, INIT counter=0, front_sel=0, swap_pending=0, wr_ready=0, busy=1, clear all pipeline valids, and drive all colour and transparent outputs to 0.
REQ-029 Reset asserted mid-COPY or mid-PEND SHALL discard the pending swap or copy and restart INIT on the next cycle.

Structure
REQ-030 A shared package (palette_pkg) SHALL hold the state enum, the rgb struct {R,G,B} of COLOR_W each, and the fixed LOOKUP_LAT=2.
REQ-031 A sub-module palette_bank (DEPTH x width, one write port, NUM_CH+1 read ports) SHALL be instantiated twice.

Verification
REQ-032 Reset, then run DEPTH+2 cycles with lookups on idx 5 -> colour 0 throughout, busy falls at cycle 256, then wr_ready=1.
REQ-033 Write idx 5=12'hFBB, then look up idx 5 -> returns 12'h000 (back bank); commit, frame_start, look up idx 5 two cycles later -> 12'hFBB.
REQ-034 Commit and frame_start in the same cycle -> no swap; the next frame_start swaps; swap_pending high in between.
REQ-035 Lookup issued the cycle before the swap -> returns the old-bank value; lookup issued the cycle after -> returns the new value.
REQ-036 After COPY, write idx 5=12'h7B4 and commit/swap -> idx 5 returns 12'h7B4 and all other indices keep their prior values.
REQ-037 Reset at COPY k=100 -> all entries 0 after INIT, front_sel=0; on channel 1, lookup of idx 0 -> transparent=1, rgb=0.
